ball_motion: RTL

- Generates the ball position on the 8x8 LED grid: column ballX, row ballY, row 0 = top (player A side), row 7 = bottom (player B side).
- Steps the ball one cell diagonally per move tick. It reflects off the side walls and off the paddles, and sends the ball into a goal row when a paddle misses.
- Sits directly upstream of the scoring stage.
  - The scoring stage adds a point on every clk cycle in which ballY is 0 or 7.
  - This block therefore guarantees that ballY holds a goal row for exactly one clk cycle per miss.

---
 rtl/pong_pkg.sv | 32 +++
 rtl/step_divider.sv | 29 ++
 rtl/ball_motion.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared pong constants: grid limits, goal rows, direction encodings,
// ball FSM states and the paddle-coverage helper.
package pong_pkg;

  localparam logic [2:0] GRID_MAX = 3'd7;
  localparam logic [2:0] ROW_A    = 3'd0;
  localparam logic [2:0] ROW_B    = 3'd7;

  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam logic DIR_UP    = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    GOAL,
    SERVE
  } state_t;

  // Widened to 4 bits so pad+width-1 cannot wrap past column 7.
  function automatic logic paddle_covers(input logic [2:0] pad,
                                         input logic [2:0] pos,
                                         input int unsigned width);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = {1'b0, pad};
    hi = lo + 4'(width - 1);
    return ({1'b0, pos} >= lo) && ({1'b0, pos} <= hi);
  endfunction

endpackage

// File: rtl/step_divider.sv
// Move-tick generator: free-running modulo-TICK_DIV counter with a
// one-clk step pulse on the last count; clear holds it at zero.
module step_divider #(
  parameter int unsigned TICK_DIV = 12500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic step
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear || r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign step = ~clear & (r_count == LAST);

endmodule

// File: rtl/ball_motion.sv
// Ball position generator for the 8x8 pong grid: diagonal motion, wall and
// paddle reflection, and a single-cycle goal row on every paddle miss.
module ball_motion
  import pong_pkg::*;
#(
  parameter int unsigned TICK_DIV = 12500000,
  parameter int unsigned PADDLE_W = 3,
  parameter int unsigned SERVE_X  = 3,
  parameter int unsigned SERVE_Y  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       playing,
  input  logic [2:0] paddleAX,
  input  logic [2:0] paddleBX,
  output logic [2:0] ballX,
  output logic [2:0] ballY,
  output logic       dirX,
  output logic       dirY,
  output logic       hitA,
  output logic       hitB
);

  localparam logic [2:0] SX     = 3'(SERVE_X);
  localparam logic [2:0] SY     = 3'(SERVE_Y);
  localparam logic [2:0] NEAR_A = ROW_A + 3'd1;
  localparam logic [2:0] NEAR_B = ROW_B - 3'd1;

  state_t     r_state;
  logic [2:0] r_ballX, r_ballY;
  logic       r_dirX, r_dirY, r_hitA, r_hitB;

  logic       w_step, w_clear;
  logic [2:0] w_nextX, w_nextY;
  logic       w_nextDirX, w_nextDirY;
  logic       w_hitA, w_hitB, w_goal;

  // Clearing on !playing as well keeps the counter at zero from the very
  // edge that drops the game back to IDLE.
  assign w_clear = (r_state == IDLE) || !playing;

  step_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clear(w_clear),
    .step (w_step)
  );

  always_comb begin
    w_nextX    = r_ballX;
    w_nextDirX = r_dirX;
    if (r_dirX == DIR_RIGHT && r_ballX == GRID_MAX) begin
      w_nextX    = GRID_MAX - 3'd1;
      w_nextDirX = DIR_LEFT;
    end else if (r_dirX == DIR_LEFT && r_ballX == 3'd0) begin
      w_nextX    = 3'd1;
      w_nextDirX = DIR_RIGHT;
    end else if (r_dirX == DIR_RIGHT) begin
      w_nextX = r_ballX + 3'd1;
    end else begin
      w_nextX = r_ballX - 3'd1;
    end
  end

  always_comb begin
    w_nextY    = r_ballY;
    w_nextDirY = r_dirY;
    w_hitA     = 1'b0;
    w_hitB     = 1'b0;
    w_goal     = 1'b0;
    if (r_dirY == DIR_UP) begin
      if (r_ballY == NEAR_A) begin
        if (paddle_covers(paddleAX, r_ballX, PADDLE_W)) begin
          w_nextY    = NEAR_A + 3'd1;
          w_nextDirY = DIR_DOWN;
          w_hitA     = 1'b1;
        end else begin
          w_nextY = ROW_A;
          w_goal  = 1'b1;
        end
      end else begin
        w_nextY = r_ballY - 3'd1;
      end
    end else begin
      if (r_ballY == NEAR_B) begin
        if (paddle_covers(paddleBX, r_ballX, PADDLE_W)) begin
          w_nextY    = NEAR_B - 3'd1;
          w_nextDirY = DIR_UP;
          w_hitB     = 1'b1;
        end else begin
          w_nextY = ROW_B;
          w_goal  = 1'b1;
        end
      end else begin
        w_nextY = r_ballY + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ballX <= SX;
      r_ballY <= SY;
      r_dirX  <= DIR_RIGHT;
      r_dirY  <= DIR_DOWN;
      r_hitA  <= 1'b0;
      r_hitB  <= 1'b0;
    end else begin
      r_hitA <= 1'b0;
      r_hitB <= 1'b0;
      if (!playing) begin
        r_state <= IDLE;
        r_ballX <= SX;
        r_ballY <= SY;
        r_dirX  <= DIR_RIGHT;
        r_dirY  <= DIR_DOWN;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_state <= MOVE;
            r_ballX <= SX;
            r_ballY <= SY;
            r_dirX  <= DIR_RIGHT;
            r_dirY  <= DIR_DOWN;
          end
          MOVE: begin
            if (w_step) begin
              r_ballX <= w_nextX;
              r_dirX  <= w_nextDirX;
              r_ballY <= w_nextY;
              r_dirY  <= w_nextDirY;
              r_hitA  <= w_hitA;
              r_hitB  <= w_hitB;
              if (w_goal) r_state <= GOAL;
            end
          end
          GOAL: begin
            r_state <= SERVE;
            r_ballX <= SX;
            r_ballY <= SY;
            r_dirY  <= (r_ballY == ROW_B) ? DIR_DOWN : DIR_UP;
          end
          SERVE: begin
            if (w_step) r_state <= MOVE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign ballX = r_ballX;
  assign ballY = r_ballY;
  assign dirX  = r_dirX;
  assign dirY  = r_dirY;
  assign hitA  = r_hitA;
  assign hitB  = r_hitB;

endmodule
